// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences PLL reset and lock, then releases the system reset
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 4
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [7:0] retries,
    output logic [2:0] state
);
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        PLLRST   = 3'd0,
        WAITLOCK = 3'd1,
        SETTLE   = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retries_q, retries_d;
    logic          lock_lost_q, lock_lost_d;
    logic          sync1_q, sync2_q;
    logic          pll_rst_q, sys_rst_q, ready_q, fail_q;
    logic          clr;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic; restart overrides everything except FAIL
    always_comb begin
        state_d     = state_q;
        retries_d   = retries_q;
        lock_lost_d = lock_lost_q;
        clr         = 1'b0;
        if (restart && state_q != FAIL) begin
            state_d     = PLLRST;
            retries_d   = '0;
            lock_lost_d = 1'b0;
            clr         = 1'b1;
        end else begin
            case (state_q)
                PLLRST: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAITLOCK;
                end
                WAITLOCK: begin
                    if (sync2_q) begin
                        state_d = SETTLE;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        if (int'(retries_q) == MAX_RETRY - 1) begin
                            state_d = FAIL;
                        end else begin
                            state_d   = PLLRST;
                            retries_d = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (!sync2_q) state_d = WAITLOCK;
                    else if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = RUN;
                end
                RUN: begin
                    if (!sync2_q) begin
                        state_d     = PLLRST;
                        lock_lost_d = 1'b1;
                        retries_d   = '0;
                    end
                end
                default: state_d = FAIL;
            endcase
        end
        cnt_d = (clr || state_d != state_q) ? '0 :
                (state_q == FAIL || state_q == RUN) ? cnt_q : cnt_q + 1'b1;
    end

    // State, counter and registered outputs derived from the next state
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            retries_q   <= '0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= (state_d == PLLRST) || (state_d == FAIL);
            sys_rst_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign fail      = fail_q;
    assign retries   = retries_q;
    assign state     = state_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed test-plan scenarios plus randomized lock/restart traffic against a reference model
module tb_pll_reset_sequencer;
    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int SET_C = 8;
    localparam int MR_C  = 3;
    localparam int P_RST = 0, P_WAIT = 1, P_SET = 2, P_RUN = 3, P_FAIL = 4;

    logic       clkin = 1'b0;
    logic       rst = 1'b1, locked = 1'b0, restart = 1'b0;
    logic       pll_rst, sys_rst, ready, lock_lost, fail;
    logic [7:0] retries;
    logic [2:0] state;

    int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
    int ph = P_RST, t_enter = 0, m_ret = 0;
    bit m_lost = 1'b0;
    bit hist[$] = '{1'b0, 1'b0};

    pll_reset_sequencer #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .SETTLE_CYCLES(SET_C), .MAX_RETRY(MR_C)
    ) dut (
        .clkin(clkin), .rst(rst), .locked(locked), .restart(restart),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .lock_lost(lock_lost),
        .fail(fail), .retries(retries), .state(state)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock edge: advance the reference model with the inputs seen at the edge, then compare
    task automatic tick();
        bit ls;
        int el, nph;
        bit clr;
        logic [4:0] ef;
        @(posedge clkin);
        cyc++;
        ls = hist[0];
        void'(hist.pop_front());
        hist.push_back(locked);
        el  = cyc - t_enter - 1;
        nph = ph;
        clr = 1'b0;
        if (rst) begin
            hist = '{1'b0, 1'b0};
            nph = P_RST; clr = 1'b1; m_ret = 0; m_lost = 1'b0;
        end else if (restart && ph != P_FAIL) begin
            nph = P_RST; clr = 1'b1; m_ret = 0; m_lost = 1'b0;
        end else if (ph == P_RST) begin
            if (el == RST_C - 1) nph = P_WAIT;
        end else if (ph == P_WAIT) begin
            if (ls) nph = P_SET;
            else if (el == TO_C - 1) begin
                if (m_ret == MR_C - 1) nph = P_FAIL;
                else begin
                    m_ret = (m_ret == 255) ? 255 : m_ret + 1;
                    nph = P_RST;
                end
            end
        end else if (ph == P_SET) begin
            if (!ls) nph = P_WAIT;
            else if (el == SET_C - 1) nph = P_RUN;
        end else if (ph == P_RUN && !ls) begin
            m_lost = 1'b1; m_ret = 0; nph = P_RST;
        end
        if (nph != ph || clr) t_enter = cyc;
        ph = nph;
        #1;
        ef = {ph == P_RST || ph == P_FAIL, ph != P_RUN, ph == P_RUN, m_lost, ph == P_FAIL};
        chk("state", state, ph);
        chk("retries", retries, m_ret);
        chk("flags", {pll_rst, sys_rst, ready, lock_lost, fail}, ef);
    endtask

    task automatic upto(input int k);
        while (cyc < t0 + k) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; restart = 1'b0; locked = 1'b0;
        tick();
        t0 = cyc;
        rst = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_prst", pll_rst, 1);
        chk("rst_sys", sys_rst, 1);
        // Normal bring-up
        upto(3);  chk("bu_prst_e3", pll_rst, 1);
        upto(4);  chk("bu_prst_e4", pll_rst, 0);
        upto(10); locked = 1'b1;
        upto(12); chk("bu_state_e12", state, 1);
        upto(13); chk("bu_state_e13", state, 2);
        upto(20); chk("bu_sys_e20", sys_rst, 1);
        upto(21); chk("bu_sys_e21", sys_rst, 0); chk("bu_rdy_e21", ready, 1); chk("bu_ret", retries, 0);
        // Loss of lock in RUN, re-lock, restart clears the sticky flag
        upto(30); locked = 1'b0;
        upto(32); chk("loss_run_e32", state, 3);
        upto(33); chk("loss_sys", sys_rst, 1); chk("loss_rdy", ready, 0);
        chk("loss_flag", lock_lost, 1); chk("loss_state", state, 0);
        locked = 1'b1;
        upto(45); chk("relock_e45", ready, 0);
        upto(46); chk("relock_e46", ready, 1); chk("relock_flag", lock_lost, 1);
        restart = 1'b1; tick(); restart = 1'b0;
        chk("restart_clr", lock_lost, 0); chk("restart_state", state, 0);
        // Restart in the same cycle locked_s falls in RUN
        upto(60); chk("sim_run", ready, 1);
        upto(62); locked = 1'b0;
        upto(64); restart = 1'b1;
        upto(65); restart = 1'b0;
        chk("sim_flag", lock_lost, 0); chk("sim_state", state, 0);
        // Glitch during SETTLE
        locked = 1'b1;
        upto(70); chk("gl_settle", state, 2);
        upto(73); locked = 1'b0;
        upto(74); locked = 1'b1;
        upto(76); chk("gl_wait", state, 1); chk("gl_ret", retries, 0);
        upto(77); chk("gl_resettle", state, 2);
        upto(84); chk("gl_e84", ready, 0);
        upto(85); chk("gl_e85", ready, 1);
        // Timeout and retry
        do_reset();
        upto(24); chk("rt_ret1", retries, 1);
        upto(48); chk("rt_ret2", retries, 2); chk("rt_state", state, 0);
        upto(53); locked = 1'b1;
        upto(56); chk("rt_settle", state, 2);
        upto(63); chk("rt_e63", ready, 0);
        upto(64); chk("rt_e64", ready, 1); chk("rt_ret_run", retries, 2); chk("rt_nofail", fail, 0);
        // rst mid-WAITLOCK with retries=1
        do_reset();
        upto(30); chk("mw_ret", retries, 1); chk("mw_state", state, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mw_rst_state", state, 0); chk("mw_rst_ret", retries, 0);
        chk("mw_rst_out", {pll_rst, sys_rst, ready, lock_lost, fail}, 5'b11000);
        // Exhaustion from the rst just applied
        t0 = cyc;
        upto(71); chk("ex_e71", fail, 0);
        upto(72); chk("ex_state", state, 4); chk("ex_fail", fail, 1);
        chk("ex_prst", pll_rst, 1); chk("ex_sys", sys_rst, 1);
        restart = 1'b1; tick(); restart = 1'b0;
        chk("ex_restart_ign", state, 4);
        upto(80);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ex_recover", state, 0); chk("ex_recover_fail", fail, 0);
        // Randomized lock behaviour with occasional restart and rst
        for (int i = 0; i < 4000; i++) begin
            if (locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 24) == 0)) locked = ~locked;
            restart = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
